// File: rtl/down_count.sv
// down_count: programmable modulo-(N+1) down counter with auto-reload or
// one-shot operation and a registered one-cycle terminal-count pulse.
// Counts N, N-1, ..., 0 on enabled clocks; at zero it either reloads the
// latched start value or parks in DONE until the next load.

`timescale 1ns/1ps

module down_count #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] N,
   input  logic             load,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] a,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q,     tc_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   // Next-state and next-output decode; load wins over everything else.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves one unassigned
      // (an unassigned path would infer a latch). tc defaults low so it is a
      // single-cycle pulse.
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      busy_d   = busy_q;
      done_d   = done_q;

      if (load) begin
         count_d  = N;
         reload_d = N;
         state_d  = RUN;
         busy_d   = 1'b1;
         done_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // en is ignored until the first load after reset
            end
            RUN: begin
               if (en) begin
                  if (count_q != ZERO) begin
                     count_d = count_q - ONE;
                  end else begin
                     // zero-crossing: pulse tc, then reload or stop
                     tc_d = 1'b1;
                     if (mode) begin
                        count_d = reload_q;
                     end else begin
                        count_d = ZERO;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               count_d = ZERO;
            end
            default: begin
               state_d = IDLE;
               count_d = ZERO;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= ZERO;
         reload_q <= ZERO;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign a    = count_q;
   assign tc   = tc_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_down_count.sv
// tb_down_count: directed and randomized checks of down_count against a
// step-counting reference model (position within the period since load).

`timescale 1ns/1ps

module tb_down_count;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] N;
   logic             load;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic             tc;
   logic             busy;
   logic             done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: m_k counts enabled steps since the last load/reload.
   int m_n;
   int m_k;
   bit m_run;
   bit m_done;
   bit m_tc;

   down_count #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .N    (N),
      .load (load),
      .en   (en),
      .mode (mode),
      .a    (a),
      .tc   (tc),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH+2:0] exp_vec();
      logic [WIDTH-1:0] ea;
      ea = m_run ? WIDTH'(m_n - m_k) : '0;
      return {ea, m_tc, m_run, m_done};
   endfunction

   function automatic logic [WIDTH+2:0] got_vec();
      return {a, tc, busy, done};
   endfunction

   task automatic model_reset();
      m_n = 0; m_k = 0; m_run = 0; m_done = 0; m_tc = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied,
   // then let the DUT take the same edge and settle.
   task automatic step();
      if (rst) begin
         model_reset();
      end else if (load) begin
         m_n = int'(N); m_k = 0; m_run = 1; m_done = 0; m_tc = 0;
      end else if (m_run && en) begin
         m_k++;
         if (m_k == m_n + 1) begin
            m_tc = 1;
            if (mode) begin
               m_k = 0;
            end else begin
               m_run = 0; m_done = 1;
            end
         end else begin
            m_tc = 0;
         end
      end else begin
         m_tc = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0; N = '0;
      model_reset();
      #2;
      total_cnt++;
      if (got_vec() !== exp_vec())
         $display("FAIL reset_async got=%h exp=%h", got_vec(), exp_vec());
      else pass_cnt++;
      step(); step();
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL idle_ignores_en cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_autoreload();
      int tc_seen;
      tc_seen = 0;
      N = 4'd11; mode = 1'b1; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      total_cnt++;
      if (a !== 4'd11 || tc !== 1'b0 || busy !== 1'b1)
         $display("FAIL autoreload_load a=%0d tc=%b busy=%b exp a=11 tc=0 busy=1", a, tc, busy);
      else pass_cnt++;
      for (int i = 0; i < 36; i++) begin
         step();
         if (tc === 1'b1) tc_seen++;
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL autoreload cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      // 36 enabled edges after load with period 12 give exactly 3 pulses
      total_cnt++;
      if (tc_seen !== 3)
         $display("FAIL autoreload_tc_count got=%0d exp=3", tc_seen);
      else pass_cnt++;
   endtask

   task automatic test_oneshot();
      N = 4'd3; mode = 1'b0; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL oneshot cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      total_cnt++;
      if (a !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0)
         $display("FAIL oneshot_final a=%0d done=%b busy=%b tc=%b exp 0 1 0 0", a, done, busy, tc);
      else pass_cnt++;
   endtask

   task automatic test_enable_gap();
      N = 4'd11; mode = 1'b1; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 20 && (m_n - m_k) != 5; i++) step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (a !== 4'd5 || tc !== 1'b0 || got_vec() !== exp_vec())
            $display("FAIL en_gap_hold cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      en = 1'b1;
      step();
      total_cnt++;
      if (a !== 4'd4 || got_vec() !== exp_vec())
         $display("FAIL en_gap_resume a=%0d exp=4", a);
      else pass_cnt++;
   endtask

   task automatic test_n_change();
      N = 4'd11; mode = 1'b1; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      step(); step(); step();
      N = 4'd2;
      for (int i = 0; i < 14; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL n_change_ignored cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      load = 1'b1;
      step();
      load = 1'b0;
      total_cnt++;
      if (a !== 4'd2 || tc !== 1'b0 || busy !== 1'b1)
         $display("FAIL reload_n2 a=%0d tc=%b busy=%b exp a=2 tc=0 busy=1", a, tc, busy);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      N = 4'd11; mode = 1'b1; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 20 && (m_n - m_k) != 7; i++) step();
      total_cnt++;
      if (a !== 4'd7)
         $display("FAIL pre_reset a=%0d exp=7", a);
      else pass_cnt++;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      total_cnt++;
      if (got_vec() !== exp_vec())
         $display("FAIL async_reset_immediate got=%h exp=%h", got_vec(), exp_vec());
      else pass_cnt++;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_n_zero_and_full();
      N = 4'd0; mode = 1'b1; en = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         total_cnt++;
         if (a !== 4'd0 || tc !== 1'b1 || got_vec() !== exp_vec())
            $display("FAIL n0_autoreload cyc=%0d a=%0d tc=%b exp a=0 tc=1", i, a, tc);
         else pass_cnt++;
      end
      mode = 1'b0; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL n0_oneshot cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      N = 4'd15; mode = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL n15_period cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load = ($urandom_range(0, 15) == 0);
         N    = WIDTH'($urandom_range(0, 15));
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         step();
         total_cnt++;
         if (got_vec() !== exp_vec())
            $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
         else pass_cnt++;
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_autoreload();
      test_oneshot();
      test_enable_gap();
      test_n_change();
      test_async_reset();
      test_n_zero_and_full();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
